// File: rtl/sprite_vga_driver.sv
// VGA raster timing plus NUM_SPRITES rectangle compositor; sprite attributes shadowed at frame end.
// Optional dashed centre net when SPRITE_VGA_CENTER_NET_EN is defined. All outputs registered once.
module sprite_vga_driver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_PULSE     = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_PULSE     = 2,
  parameter int V_BACK      = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int NUM_SPRITES = 3,
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int COLOR_BITS  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SPRITES*X_W-1:0]          sprite_x,
  input  logic [NUM_SPRITES*Y_W-1:0]          sprite_y,
  input  logic [NUM_SPRITES*X_W-1:0]          sprite_w,
  input  logic [NUM_SPRITES*Y_W-1:0]          sprite_h,
  input  logic [NUM_SPRITES*3*COLOR_BITS-1:0] sprite_color,
  input  logic [NUM_SPRITES-1:0]              sprite_en,
  input  logic [3*COLOR_BITS-1:0]             bg_color,
  output logic                              hsync_s,
  output logic                              vsync_s,
  output logic [COLOR_BITS-1:0]               red_s,
  output logic [COLOR_BITS-1:0]               green_s,
  output logic [COLOR_BITS-1:0]               blue_s,
  output logic                              frame_start_s
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW = 3 * COLOR_BITS;
  // Compare widths hold both the counter and the one-bit-wider edge sum.
  localparam int XC = (X_W + 1 > HW) ? X_W + 1 : HW;
  localparam int YC = (Y_W + 1 > VW) ? Y_W + 1 : VW;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last, active, hs_on, vs_on, started;

  logic [NUM_SPRITES*X_W-1:0] sh_x, sh_w;
  logic [NUM_SPRITES*Y_W-1:0] sh_y, sh_h;
  logic [NUM_SPRITES*CW-1:0]  sh_color;
  logic [NUM_SPRITES-1:0]     sh_en, hit;
  logic [CW-1:0]              pix;
  logic [XC-1:0]              hx;
  logic [YC-1:0]              vy;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));
  assign active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign hs_on  = (h_cnt >= HW'(H_ACTIVE + H_FRONT)) && (h_cnt < HW'(H_ACTIVE + H_FRONT + H_PULSE));
  assign vs_on  = (v_cnt >= VW'(V_ACTIVE + V_FRONT)) && (v_cnt < VW'(V_ACTIVE + V_FRONT + V_PULSE));
  assign hx     = XC'(h_cnt);
  assign vy     = YC'(v_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_x     <= '0;
      sh_y     <= '0;
      sh_w     <= '0;
      sh_h     <= '0;
      sh_color <= '0;
      sh_en    <= '0;
    end else if (h_last && v_last) begin
      sh_x     <= sprite_x;
      sh_y     <= sprite_y;
      sh_w     <= sprite_w;
      sh_h     <= sprite_h;
      sh_color <= sprite_color;
      sh_en    <= sprite_en;
    end
  end

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    logic [XC-1:0] xs, xe;
    logic [YC-1:0] ys, ye;
    assign xs     = XC'(sh_x[i*X_W +: X_W]);
    assign xe     = xs + XC'(sh_w[i*X_W +: X_W]);
    assign ys     = YC'(sh_y[i*Y_W +: Y_W]);
    assign ye     = ys + YC'(sh_h[i*Y_W +: Y_W]);
    assign hit[i] = sh_en[i] && (hx >= xs) && (hx < xe) && (vy >= ys) && (vy < ye);
  end

`ifdef SPRITE_VGA_CENTER_NET_EN
  logic [31:0] v_wide;
  logic        net;
  assign v_wide = 32'(v_cnt);
  assign net    = ((h_cnt == HW'(H_ACTIVE/2 - 1)) || (h_cnt == HW'(H_ACTIVE/2))) && !v_wide[3];
`endif

  // Walk from the highest index down so the lowest-index hit lands last and wins.
  always_comb begin
    pix = '0;
    if (active) begin
      pix = bg_color;
`ifdef SPRITE_VGA_CENTER_NET_EN
      if (net) pix = '1;
`endif
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
        if (hit[i]) pix = sh_color[i*CW +: CW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_s       <= ~HSYNC_POL;
      vsync_s       <= ~VSYNC_POL;
      red_s         <= '0;
      green_s       <= '0;
      blue_s        <= '0;
      frame_start_s <= 1'b0;
      started       <= 1'b0;
    end else begin
      hsync_s       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      vsync_s       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      red_s         <= pix[2*COLOR_BITS +: COLOR_BITS];
      green_s       <= pix[COLOR_BITS +: COLOR_BITS];
      blue_s        <= pix[0 +: COLOR_BITS];
      frame_start_s <= started && (h_cnt == '0) && (v_cnt == '0);
      if (h_last && v_last) started <= 1'b1;
    end
  end

endmodule
